// File: rtl/alu_flag_monitor.sv
// ALU status flag monitor: registers qualified flags, counts flag events,
// and traps with a halt request on a qualified signed overflow.
module alu_flag_monitor #(
  parameter int unsigned CNT_W   = 16,
  parameter bit          TRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             negative,
  input  logic             Zero,
  input  logic             Cout,
  input  logic             overflow,
  input  logic             clr,
  input  logic [1:0]       sel,
  output logic [CNT_W-1:0] count_out,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [3:0]       flags_q,
  output logic             sticky_ovf,
  output logic             trap,
  output logic             halt_req
);

  typedef enum logic {
    MONITOR = 1'b0,
    TRAPPED = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MAX = '1;

  state_e                 state_q, state_d;
  logic                   trap_q, trap_d;
  logic [3:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]       samp_q, samp_d;
  logic [3:0]             flags_d;
  logic                   sticky_q, sticky_d;
  logic [3:0]             flg_in;
  logic                   acc;

  assign flg_in = {overflow, Cout, Zero, negative};
  assign acc    = en & (state_q == MONITOR) & ~clr;

  // Next-state and trap pulse; clr forces the monitor back to MONITOR
  always_comb begin
    state_d = state_q;
    trap_d  = 1'b0;
    if (clr) begin
      state_d = MONITOR;
    end else begin
      unique case (state_q)
        MONITOR: begin
          if (acc & overflow & TRAP_EN) begin
            state_d = TRAPPED;
            trap_d  = 1'b1;
          end
        end
        TRAPPED: state_d = TRAPPED;
        default: state_d = MONITOR;
      endcase
    end
  end

  // Saturating event counters, sample counter, flag capture and sticky
  always_comb begin
    cnt_d    = cnt_q;
    samp_d   = samp_q;
    flags_d  = flags_q;
    sticky_d = sticky_q;
    if (clr) begin
      cnt_d    = '0;
      samp_d   = '0;
      flags_d  = '0;
      sticky_d = 1'b0;
    end else if (acc) begin
      flags_d = flg_in;
      if (samp_q != MAX) samp_d = samp_q + 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (flg_in[i] && cnt_q[i] != MAX) cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (overflow) sticky_d = 1'b1;
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MONITOR;
      trap_q   <= 1'b0;
      cnt_q    <= '0;
      samp_q   <= '0;
      flags_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      trap_q   <= trap_d;
      cnt_q    <= cnt_d;
      samp_q   <= samp_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
    end
  end

  assign count_out  = cnt_q[sel];
  assign sample_cnt = samp_q;
  assign sticky_ovf = sticky_q;
  assign trap       = trap_q;
  assign halt_req   = (state_q == TRAPPED);

endmodule

// File: tb/tb_alu_flag_monitor.sv
// Bench for alu_flag_monitor: three instances (default, 4-bit counters,
// trap disabled) share stimulus and are checked against a flag-level model.
module tb_alu_flag_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, negative = 1'b0, Zero = 1'b0, Cout = 1'b0, overflow = 1'b0;
  logic clr = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [15:0] a_cnt, a_samp, c_cnt, c_samp;
  logic [3:0]  b_cnt, b_samp;
  logic [3:0]  a_flg, b_flg, c_flg;
  logic a_stk, b_stk, c_stk, a_trp, b_trp, c_trp, a_hlt, b_hlt, c_hlt;

  int total = 0;
  int bad = 0;

  always #10 clk = ~clk;

  alu_flag_monitor #(.CNT_W(16), .TRAP_EN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .negative(negative), .Zero(Zero),
    .Cout(Cout), .overflow(overflow), .clr(clr), .sel(sel),
    .count_out(a_cnt), .sample_cnt(a_samp), .flags_q(a_flg),
    .sticky_ovf(a_stk), .trap(a_trp), .halt_req(a_hlt));

  alu_flag_monitor #(.CNT_W(4), .TRAP_EN(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .negative(negative), .Zero(Zero),
    .Cout(Cout), .overflow(overflow), .clr(clr), .sel(sel),
    .count_out(b_cnt), .sample_cnt(b_samp), .flags_q(b_flg),
    .sticky_ovf(b_stk), .trap(b_trp), .halt_req(b_hlt));

  alu_flag_monitor #(.CNT_W(16), .TRAP_EN(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .negative(negative), .Zero(Zero),
    .Cout(Cout), .overflow(overflow), .clr(clr), .sel(sel),
    .count_out(c_cnt), .sample_cnt(c_samp), .flags_q(c_flg),
    .sticky_ovf(c_stk), .trap(c_trp), .halt_req(c_hlt));

  // reference model, one entry per instance (0=a, 1=b, 2=c)
  int mx[3]  = '{65535, 15, 65535};
  bit ten[3] = '{1'b1, 1'b1, 1'b0};
  int m_cnt[3][4];
  int m_samp[3];
  int m_flg[3];
  bit m_stk[3], m_trp[3], m_halt[3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
      m_samp[i] = 0; m_flg[i] = 0;
      m_stk[i] = 0; m_trp[i] = 0; m_halt[i] = 0;
    end
  endtask

  task automatic model_edge(bit e, bit [3:0] f, bit c);
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
        m_samp[i] = 0; m_flg[i] = 0;
        m_stk[i] = 0; m_trp[i] = 0; m_halt[i] = 0;
      end else begin
        m_trp[i] = 0;
        if (e && !m_halt[i]) begin
          m_flg[i] = f;
          if (m_samp[i] < mx[i]) m_samp[i]++;
          for (int k = 0; k < 4; k++)
            if (f[k] && m_cnt[i][k] < mx[i]) m_cnt[i][k]++;
          if (f[3]) begin
            m_stk[i] = 1;
            if (ten[i]) begin
              m_halt[i] = 1;
              m_trp[i] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_samp", int'(a_samp), m_samp[0]);
    chk("b_samp", int'(b_samp), m_samp[1]);
    chk("c_samp", int'(c_samp), m_samp[2]);
    chk("a_flg", int'(a_flg), m_flg[0]);
    chk("b_flg", int'(b_flg), m_flg[1]);
    chk("c_flg", int'(c_flg), m_flg[2]);
    chk("a_stk", int'(a_stk), int'(m_stk[0]));
    chk("b_stk", int'(b_stk), int'(m_stk[1]));
    chk("c_stk", int'(c_stk), int'(m_stk[2]));
    chk("a_trap", int'(a_trp), int'(m_trp[0]));
    chk("b_trap", int'(b_trp), int'(m_trp[1]));
    chk("c_trap", int'(c_trp), int'(m_trp[2]));
    chk("a_halt", int'(a_hlt), int'(m_halt[0]));
    chk("b_halt", int'(b_hlt), int'(m_halt[1]));
    chk("c_halt", int'(c_hlt), int'(m_halt[2]));
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("a_cnt%0d", s), int'(a_cnt), m_cnt[0][s]);
      chk($sformatf("b_cnt%0d", s), int'(b_cnt), m_cnt[1][s]);
      chk($sformatf("c_cnt%0d", s), int'(c_cnt), m_cnt[2][s]);
    end
  endtask

  // one clock: drive on negedge, model at posedge, check 1ns later
  task automatic step(bit e, bit [3:0] f, bit c);
    @(negedge clk);
    en = e; {overflow, Cout, Zero, negative} = f; clr = c;
    @(posedge clk);
    model_edge(e, f, c);
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    en = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    // T1: reset
    model_reset();
    #7;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 4'b0000, 0);

    // T2: 5 Zero samples and 2 negative samples with idle gaps
    for (int i = 0; i < 5; i++) begin
      step(1, 4'b0010, 0);
      step(0, 4'b1111, 0);
    end
    step(1, 4'b0001, 0);
    step(0, 4'b0101, 0);
    step(1, 4'b0001, 0);
    sel = 2'd1; #1;
    chk("t2_zero5", int'(a_cnt), 5);
    sel = 2'd0; #1;
    chk("t2_neg2", int'(a_cnt), 2);
    chk("t2_samp7", int'(a_samp), 7);

    // T3: 20 Cout samples saturate the 4-bit instance
    step(0, 4'b0000, 1);
    for (int i = 0; i < 20; i++) step(1, 4'b0100, 0);
    sel = 2'd2; #1;
    chk("t3_sat15", int'(b_cnt), 15);
    chk("t3_samp15", int'(b_samp), 15);
    chk("t3_a20", int'(a_cnt), 20);

    // T4/T5: overflow traps a/b, c only counts
    step(0, 4'b0000, 1);
    step(1, 4'b1000, 0);
    chk("t4_trap", int'(a_trp), 1);
    chk("t4_halt", int'(a_hlt), 1);
    step(1, 4'b1111, 0);
    chk("t4_trap_once", int'(a_trp), 0);
    step(1, 4'b1000, 0);
    step(0, 4'b0000, 0);
    sel = 2'd3; #1;
    chk("t4_ovf1", int'(a_cnt), 1);
    chk("t5_ovf3", int'(c_cnt), 3);
    chk("t5_nohalt", int'(c_hlt), 0);
    step(0, 4'b0000, 1);
    chk("t4_clr_halt", int'(a_hlt), 0);

    // T6: clr collides with a Zero sample; reset while trapped
    step(1, 4'b0010, 1);
    chk("t6_samp0", int'(a_samp), 0);
    step(1, 4'b1000, 0);
    step(0, 4'b0000, 0);
    pulse_reset();
    chk("t6_rst_halt", int'(a_hlt), 0);
    step(1, 4'b1000, 0);
    pulse_reset();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit [3:0] f;
      f[2:0] = 3'($urandom);
      f[3] = ($urandom % 8) == 0;
      if (($urandom % 97) == 0) pulse_reset();
      else step(($urandom % 4) != 0, f, ($urandom % 30) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
